// File: rtl/alu_arbiter_if.sv
// Per-requester command/response channel into the shared-ALU arbiter.
// master = CPU-side issuer, slave = arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [OPW-1:0]   op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] z;
  logic [2:0]       flags;

  modport master (output valid, x, y, op, rsp_ready,
                  input  ready, rsp_valid, z, flags);
  modport slave  (input  valid, x, y, op, rsp_ready,
                  output ready, rsp_valid, z, flags);
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters: IDLE (arbitrate/accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rstb,
  alu_arbiter_if.slave       req0,
  alu_arbiter_if.slave       req1,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_z,
  input  logic               alu_equal,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               busy,
  output logic [COUNT_W-1:0] ops_done0,
  output logic [COUNT_W-1:0] ops_done1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [OPW-1:0]   op;
  } cmd_t;

  state_t           state;
  logic             last_grant, grant, sel, hs;
  logic [1:0]       vld, rsp_rdy, rsp_vld;
  cmd_t [1:0]       cmds;
  cmd_t             opnd;
  logic [WIDTH-1:0] res_z;
  logic [2:0]       res_flags;

  assign vld     = {req1.valid, req0.valid};
  assign rsp_rdy = {req1.rsp_ready, req0.rsp_ready};
  assign cmds[0] = {req0.x, req0.y, req0.op};
  assign cmds[1] = {req1.x, req1.y, req1.op};

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign sel = (&vld) ? ~last_grant : vld[1];
  assign hs  = |(rsp_vld & rsp_rdy);

  // Ready is held low while reset is applied even though state already reads IDLE.
  assign req0.ready = rstb && (state == IDLE) && vld[0] && !sel;
  assign req1.ready = rstb && (state == IDLE) && vld[1] &&  sel;

  assign req0.rsp_valid = rsp_vld[0];
  assign req1.rsp_valid = rsp_vld[1];
  assign req0.z         = res_z;
  assign req1.z         = res_z;
  assign req0.flags     = res_flags;
  assign req1.flags     = res_flags;

  assign {alu_x, alu_y, alu_op} = opnd;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      opnd       <= '0;
      res_z      <= '0;
      res_flags  <= '0;
      rsp_vld    <= '0;
      ops_done0  <= '0;
      ops_done1  <= '0;
    end else begin
      case (state)
        IDLE: if (|vld) begin
          opnd  <= cmds[sel];
          grant <= sel;
          state <= EXEC;
        end
        EXEC: begin
          res_z          <= alu_z;
          res_flags      <= {alu_equal, alu_overflow, alu_zero};
          rsp_vld[grant] <= 1'b1;
          state          <= RESP;
        end
        RESP: if (hs) begin
          rsp_vld    <= '0;
          last_grant <= grant;
          state      <= IDLE;
          if (grant) begin
            if (ops_done1 != '1) ops_done1 <= ops_done1 + COUNT_W'(1);
          end else begin
            if (ops_done0 != '1) ops_done0 <= ops_done0 + COUNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter; a second instance with a 2-bit
// counter shadows the main one to exercise counter saturation.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int OPW = 4;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2,
                         OP_ADD = 4'd3, OP_SUB = 4'd4, OP_BAD = 4'hF;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .OPW(OPW)) r0 (), r1 (), s0 (), s1 ();

  logic [W-1:0]   alu_x, alu_y, alu_z, sx, sy, sz;
  logic [OPW-1:0] alu_op, sop;
  logic           ae, ao, az, se, so, szf;
  logic           busy, sbusy;
  logic [15:0]    done0, done1;
  logic [1:0]     sdone0, sdone1;

  // Behavioural ALU: returns {equal, overflow, zero, z}.
  function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] z;
    logic        ov;
    z = '0;
    ov = 1'b0;
    case (op)
      OP_AND: z = x & y;
      OP_OR:  z = x | y;
      OP_XOR: z = x ^ y;
      OP_ADD: begin z = x + y; ov = (x[31] == y[31]) && (z[31] != x[31]); end
      OP_SUB: begin z = x - y; ov = (x[31] != y[31]) && (z[31] != x[31]); end
      default: z = '0;
    endcase
    return {x == y, ov, z == 32'd0, z};
  endfunction

  assign {ae, ao, az, alu_z} = ref_alu(alu_op, alu_x, alu_y);
  assign {se, so, szf, sz}   = ref_alu(sop, sx, sy);

  assign s0.valid = r0.valid;  assign s0.x = r0.x;  assign s0.y = r0.y;
  assign s0.op = r0.op;        assign s0.rsp_ready = r0.rsp_ready;
  assign s1.valid = r1.valid;  assign s1.x = r1.x;  assign s1.y = r1.y;
  assign s1.op = r1.op;        assign s1.rsp_ready = r1.rsp_ready;

  alu_arbiter #(.WIDTH(W), .OPW(OPW), .COUNT_W(16)) dut (
    .clk(clk), .rstb(rstb), .req0(r0), .req1(r1),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
    .alu_equal(ae), .alu_overflow(ao), .alu_zero(az),
    .busy(busy), .ops_done0(done0), .ops_done1(done1));

  alu_arbiter #(.WIDTH(W), .OPW(OPW), .COUNT_W(2)) dut_sat (
    .clk(clk), .rstb(rstb), .req0(s0), .req1(s1),
    .alu_x(sx), .alu_y(sy), .alu_op(sop), .alu_z(sz),
    .alu_equal(se), .alu_overflow(so), .alu_zero(szf),
    .busy(sbusy), .ops_done0(sdone0), .ops_done1(sdone1));

  int n_chk = 0;
  int n_err = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  bit last = 1'b1;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt0 = 0;
    cnt1 = 0;
    last = 1'b1;
  endtask

  // Drives one transaction on port p to completion; returns z/flags seen in RESP.
  task automatic serve(input int p, input bit drop, input int stall,
                       output logic [31:0] gz, output logic [2:0] gf);
    logic [31:0] ex, ey;
    logic [3:0]  eop;
    logic [34:0] e;
    int n;
    n = 0;
    while (!(p != 0 ? r1.ready : r0.ready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant_ready", p != 0 ? r1.ready : r0.ready, 1);
    chk("other_ready", p != 0 ? r0.ready : r1.ready, 0);
    ex  = p != 0 ? r1.x  : r0.x;
    ey  = p != 0 ? r1.y  : r0.y;
    eop = p != 0 ? r1.op : r0.op;
    e   = ref_alu(eop, ex, ey);
    @(posedge clk); #1;
    if (drop) begin
      if (p != 0) r1.valid = 1'b0; else r0.valid = 1'b0;
    end
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_rsp", {r1.rsp_valid, r0.rsp_valid}, 0);
    chk("exec_alu_in", {alu_x, alu_y, alu_op}, {ex, ey, eop});
    gz = '0;
    gf = '0;
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      if (k == 0) begin
        gz = p != 0 ? r1.z : r0.z;
        gf = p != 0 ? r1.flags : r0.flags;
      end
      chk("rsp_valid", {r1.rsp_valid, r0.rsp_valid}, p != 0 ? 2'b10 : 2'b01);
      chk("rsp_z", p != 0 ? r1.z : r0.z, e[31:0]);
      chk("rsp_flags", p != 0 ? r1.flags : r0.flags, e[34:32]);
      chk("resp_req_ready", {r1.ready, r0.ready}, 0);
      chk("resp_busy", busy, 1);
      chk("resp_alu_hold", {alu_x, alu_y, alu_op}, {ex, ey, eop});
    end
    if (p != 0) r1.rsp_ready = 1'b1; else r0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (p != 0) begin r1.rsp_ready = 1'b0; cnt1++; end
    else begin r0.rsp_ready = 1'b0; cnt0++; end
    last = (p != 0);
    @(negedge clk);
    chk("rsp_drop", {r1.rsp_valid, r0.rsp_valid}, 0);
    chk("ops_done0", done0, cnt0);
    chk("ops_done1", done1, cnt1);
    chk("sat_done0", sdone0, cnt0 > 3 ? 3 : cnt0);
    chk("sat_done1", sdone1, cnt1 > 3 ? 3 : cnt1);
  endtask

  task automatic set_cmd(input int p, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    if (p != 0) begin r1.valid = 1'b1; r1.x = x; r1.y = y; r1.op = op; end
    else        begin r0.valid = 1'b1; r0.x = x; r0.y = y; r0.op = op; end
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] t;
    t = 4'($urandom_range(0, 5));
    return (t == 4'd5) ? OP_BAD : t;
  endfunction

  initial begin
    logic [31:0] gz;
    logic [2:0]  gf;
    bit [1:0]    pend;
    int          w;
    logic [31:0] rx;

    r0.valid = 0; r0.x = 0; r0.y = 0; r0.op = 0; r0.rsp_ready = 0;
    r1.valid = 0; r1.x = 0; r1.y = 0; r1.op = 0; r1.rsp_ready = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", {r1.rsp_valid, r0.rsp_valid}, 0);
    chk("rst_rsp_z", {r0.z, r1.z}, 0);
    chk("rst_rsp_flags", {r0.flags, r1.flags}, 0);
    chk("rst_alu", {alu_x, alu_y, alu_op}, 0);
    chk("rst_done", {done0, done1}, 0);

    // Both requesters valid from reset release: port 0 first, then alternation.
    set_cmd(0, 32'h5, 32'h5, OP_XOR);
    set_cmd(1, 32'hA, 32'h3, OP_XOR);
    #10;
    chk("rst_req_ready", {r1.ready, r0.ready}, 0);
    @(negedge clk); rstb = 1'b1; #1;
    model_reset();
    serve(0, 0, 0, gz, gf);
    chk("xor_p0_z", gz, 0);
    chk("xor_p0_flags", gf, 3'b101);
    serve(1, 0, 0, gz, gf);
    chk("xor_p1_z", gz, 32'h9);
    chk("xor_p1_flags", gf, 3'b000);
    serve(0, 0, 0, gz, gf);
    serve(1, 0, 0, gz, gf);
    r0.valid = 1'b0;
    r1.valid = 1'b0;

    // Single-port directed cases.
    set_cmd(0, 32'hF0F0F0F0, 32'hFF00FF00, OP_AND); #1;
    serve(0, 1, 0, gz, gf);
    chk("and_z", gz, 32'hF000F000);
    chk("and_flags", gf, 3'b000);
    set_cmd(1, 32'h7FFFFFFF, 32'h00000001, OP_ADD); #1;
    serve(1, 1, 0, gz, gf);
    chk("add_ovf_z", gz, 32'h80000000);
    chk("add_ovf_flags", gf, 3'b010);

    // Backpressure with a stray rsp_ready on the idle port.
    set_cmd(0, 32'h10, 32'h3, OP_SUB);
    r1.rsp_ready = 1'b1; #1;
    serve(0, 1, 5, gz, gf);
    chk("sub_z", gz, 32'h0000000D);
    r1.rsp_ready = 1'b0;

    // Reset during EXEC drops the port-1 transaction.
    set_cmd(1, 32'h1234, 32'h00FF, OP_OR); #1;
    chk("mid_ready1", r1.ready, 1);
    @(posedge clk); #1;
    chk("mid_exec_busy", busy, 1);
    rstb = 1'b0;
    r1.valid = 1'b0;
    #1;
    model_reset();
    chk("mid_busy", busy, 0);
    chk("mid_rsp1", r1.rsp_valid, 0);
    chk("mid_done1", done1, 0);
    @(negedge clk); rstb = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp", {r1.rsp_valid, r0.rsp_valid}, 0);
      chk("post_rst_busy", busy, 0);
    end
    set_cmd(0, $urandom, $urandom, OP_XOR);
    set_cmd(1, $urandom, $urandom, OP_ADD); #1;
    serve(0, 1, 0, gz, gf);
    serve(1, 1, 0, gz, gf);

    // Fresh reset, then invalid op codes drive the 2-bit counter into saturation.
    @(negedge clk); rstb = 1'b0; #2; rstb = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      set_cmd(0, $urandom, $urandom, OP_BAD); #1;
      serve(0, 1, 0, gz, gf);
      chk("bad_op_z", gz, 0);
      chk("sat_seq", sdone0, i < 3 ? i + 1 : 3);
    end

    // Randomized traffic: a losing requester keeps its command pending.
    pend = 2'b00;
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          rx = $urandom;
          set_cmd(p, rx, ($urandom_range(0, 3) == 0) ? rx : $urandom, rand_op());
          pend[p] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        w = $urandom_range(0, 1);
        set_cmd(w, $urandom, $urandom, rand_op());
        pend[w] = 1'b1;
      end
      w = (pend == 2'b11) ? int'(!last) : (pend[1] ? 1 : 0);
      if (w != 0) r0.rsp_ready = 1'($urandom_range(0, 1));
      else        r1.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      serve(w, 1, $urandom_range(0, 3), gz, gf);
      pend[w] = 1'b0;
      r0.rsp_ready = 1'b0;
      r1.rsp_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one combinational alu instance (32-bit X/Y, 4-bit op_code, Z plus equal/overflow/zero flags).
- Each requester issues commands and gets responses over its own valid/ready handshake.
- The block registers operands, drives the ALU from those registers, captures the result and flags, and returns them to the granted requester.
- It sits between CPU-side issue logic and the shared alu.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- OPW, 4, op_code width; values are the ALU_OP_* defines in alu_defines.v.
- COUNT_W, 16, width of the per-port completed-operation counters.

Ports:
- clk  input  1  system clock, rising edge.
- rstb  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  requester 0/1 command valid.
- req0_ready / req1_ready  output  1  command accepted this cycle.
- req0_x, req0_y / req1_x, req1_y  input  WIDTH  operands.
- req0_op / req1_op  input  OPW  ALU op code.
- rsp0_valid / rsp1_valid  output  1  response valid.
- rsp0_ready / rsp1_ready  input  1  requester consumes response.
- rsp0_z / rsp1_z  output  WIDTH  result.
- rsp0_flags / rsp1_flags  output  3  {equal, overflow, zero}.
- alu_x, alu_y  output  WIDTH  operands to shared alu.
- alu_op  output  OPW  op_code to shared alu.
- alu_z  input  WIDTH  alu result.
- alu_equal, alu_overflow, alu_zero  input  1  alu flags.
- busy  output  1  high in any state other than IDLE.
- ops_done0 / ops_done1  output  COUNT_W  completed responses per port.

Behaviour:
- Reset (rstb low, asynchronous):
  - State = IDLE; last_grant = 1, so port 0 wins first.
  - All rsp outputs, alu_x/alu_y/alu_op, captured result/flags and counters = 0.
  - busy = 0; req*_ready = 0.
- FSM IDLE:
  - req_ready is combinational and high only for the port that would be granted.
  - If both valid: grant = ~last_grant. If one valid: grant that port. If none: stay IDLE.
  - On accept (valid & ready): latch x, y, op into operand registers, record grant, go to EXEC.
- FSM EXEC (exactly 1 cycle):
  - alu_x/alu_y/alu_op are driven from the operand registers only. They never come combinationally from the req ports.
  - At the end of EXEC, capture alu_z and the three flags. Go to RESP.
- FSM RESP:
  - rsp_valid is high for the granted port only, with z and flags held stable.
  - Stay in RESP while rsp_ready is low; both req_ready stay low.
  - On rsp_valid & rsp_ready: last_grant = grant, that port's counter increments, go to IDLE.
  - rsp_valid drops in the cycle after the handshake.
- Latency and throughput:
  - Command accepted in cycle N; rsp_valid is high from cycle N+2.
  - Minimum 3 cycles per operation.
  - No new accept in the cycle of a response handshake.
- Operand registers hold their values outside EXEC, so alu inputs stay stable through RESP.
- Invalid op codes are passed to the alu unchanged. The alu returns Z = 0, which is forwarded. No error is raised.
- ops_done counters saturate at all-ones and never wrap.
- An ungranted requester holding valid keeps its command. Its req_ready stays 0 until the arbiter returns to IDLE and grants it. A port is never starved: with both valid continuously, grants strictly alternate.
- req_valid deasserted in IDLE before accept: no transaction, no state change.
- Reset in EXEC or RESP: the transaction is dropped and no response is issued. Counters clear. After release, port 0 has priority again.
- rsp_ready asserted for the non-granted port: ignored.

Test Plan:
- Port 0 only, op ALU_OP_AND, X=F0F0F0F0, Y=FF00FF00, accept cycle N -> rsp0_valid at N+2, rsp0_z=F000F000, flags=000, ops_done0=1.
- Port 1 only, ALU_OP_ADD, X=7FFFFFFF, Y=00000001 -> rsp1_z=80000000, overflow=1, zero=0; rsp0_valid never asserts.
- Both valid from release of reset with ALU_OP_XOR:
  - port 0 {X=5, Y=5}, port 1 {X=A, Y=3}.
  - Required: port 0 served first (z=0, zero=1, equal=1), then port 1 (z=9).
  - With both held valid, grants alternate 0,1,0,1 over 4 operations.
- Backpressure: port 0 ALU_OP_SUB X=10 Y=3, rsp0_ready low for 5 cycles in RESP -> rsp0_valid high and rsp0_z=0000000D stable all 5 cycles; req0_ready and req1_ready stay 0; busy=1; completes on the 6th cycle.
- Reset mid-operation: assert rstb low during EXEC of a port 1 request -> immediately busy=0 and rsp1_valid=0; no response after release; ops_done1=0; the next simultaneous request goes to port 0.
- COUNT_W=2, issue 5 port-0 ops with op code 4'b1111 -> each rsp0_z=0; ops_done0 reads 1,2,3,3,3.
